mem_bneck_pingpong: RTL and testbench
=====================================

Name: mem_bneck_pingpong

Overview:
Double-buffered (ping-pong) activation memory for the bottleneck stages. The block generalises the 16-lane bottleneck feature memory to LANES lanes and DEPTH words per bank. One bank takes producer writes while the other serves consumer reads, with a handshaked bank swap. It adds a per-lane write mask, a registered read with a valid flag, out-of-range index detection, and a hardware zero-fill of the write bank.

Parameters:
LANES, 16, number of parallel channel lanes per word
BITSIZE, 16, bits per lane element
DEPTH, 12544, words per bank (112*112)
ADDR_W, 14, index width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous active-low reset
en  in  1  enable for rd/wr; swap and clear run regardless
wr  in  1  write strobe to the write bank
wr_index  in  ADDR_W  write word index
wr_mask  in  LANES  per-lane write enable; 1 = lane written
data_in  in  LANES*BITSIZE  write data; lane i at [i*BITSIZE +: BITSIZE]
rd  in  1  read strobe from the read bank
rd_index  in  ADDR_W  read word index
data_out  out  LANES*BITSIZE  registered read data
rd_valid  out  1  data_out valid pulse
swap_req  in  1  request to exchange banks
swap_ack  out  1  one-cycle pulse when the swap has taken effect
bank_sel  out  1  current write bank; read bank = ~bank_sel
clr_start  in  1  start zero-fill of the write bank
clr_busy  out  1  zero-fill in progress
idx_err  out  1  one-cycle pulse: accepted rd or wr had index >= DEPTH

Behaviour:
- Reset (rst=0, async): bank_sel=0, data_out=0, rd_valid=0, swap_ack=0, clr_busy=0, idx_err=0. The FSM goes to IDLE and the swap-pending flag is cleared. Memory arrays are not reset.
- Reset mid-clear aborts the clear; words already zeroed stay zero.
- Write: en&wr&!clr_busy&(wr_index<DEPTH) writes masked lanes of bank[bank_sel] at the clock edge. Unmasked lanes keep their old value.
- Write while clr_busy is dropped silently; idx_err does not fire.
- Read: en&rd returns bank[~bank_sel][rd_index] on data_out with rd_valid=1 on the next cycle (latency 1).
- When no read is accepted, data_out holds its last value and rd_valid=0.
- rd_index >= DEPTH: data_out=0, rd_valid=1, idx_err=1 the next cycle. wr_index >= DEPTH: write dropped, idx_err=1 the next cycle.
- If both rd and wr are out of range in the same cycle, idx_err pulses once.
- Same-cycle rd and wr never conflict, because they always target different banks.
- Swap: swap_req sampled at rising edge sets the pending flag.
  - In IDLE, pending executes the same edge: bank_sel toggles and swap_ack=1 for the following cycle.
  - A wr in the swap cycle goes to the old write bank. An rd in the swap cycle reads the old read bank.
  - swap_req held high for multiple cycles counts as one request per rising edge of swap_req, not per cycle.
- Clear FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start. The address counter is set to 0 and clr_busy=1 from the next cycle.
  - CLEAR writes all-zero (all lanes) to bank[bank_sel] at counter, one word per cycle, incrementing the counter.
  - After writing DEPTH-1, the FSM returns to IDLE and clr_busy falls. Total clr_busy duration = DEPTH cycles.
  - clr_start during CLEAR is ignored.
  - swap_req during CLEAR is held pending and executes on the first IDLE edge. The clear always completes on the bank it started on.
  - clr_start and swap_req on the same edge in IDLE: the swap executes first and the clear targets the new write bank.
  - Reads are unaffected by CLEAR.
- Width rules: counter is ADDR_W bits. Index comparisons are unsigned against DEPTH.

Test Plan:
- Reset then ping-pong: write word 5 = lanes 0..15 = 0x0001..0x0010 in bank 0, swap_req -> swap_ack one cycle later, bank_sel=1. rd 5 -> data_out=written pattern with rd_valid one cycle after rd.
- Write mask: after a full write of 0xFFFF to word 7, write 0x0000 with wr_mask=0x00FF, swap, read 7 -> lanes 0..7 = 0, lanes 8..15 = 0xFFFF.
- Out-of-range: rd_index=12544 -> data_out=0, rd_valid=1, idx_err=1. wr_index=16383 -> no memory change, idx_err=1.
- Clear: with DEPTH=16, fill bank 0, clr_start -> clr_busy high exactly 16 cycles, then swap and read all 16 -> 0. A wr during clr_busy is dropped.
- Swap during clear: swap_req at clear cycle 3 -> bank_sel unchanged until clr_busy falls, then it toggles and swap_ack pulses once.
- Async reset mid-clear and mid-read: rst low asynchronously -> all outputs 0 immediately, bank_sel=0. After release, the FSM is IDLE and no pending swap executes.

Source files
------------

// File: rtl/mem_bneck_pingpong.sv
// Ping-pong activation memory: one bank takes masked producer writes while the
// other serves registered consumer reads; banks exchange on a handshaked swap.
module mem_bneck_pingpong #(
  parameter int LANES   = 16,
  parameter int BITSIZE = 16,
  parameter int DEPTH   = 12544,
  parameter int ADDR_W  = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr,
  input  logic [ADDR_W-1:0]          wr_index,
  input  logic [LANES-1:0]           wr_mask,
  input  logic [LANES*BITSIZE-1:0]   data_in,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          rd_index,
  output logic [LANES*BITSIZE-1:0]   data_out,
  output logic                       rd_valid,
  input  logic                       swap_req,
  output logic                       swap_ack,
  output logic                       bank_sel,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output logic                       idx_err
);

  // state    | meaning
  // ST_IDLE  | normal operation, pending swaps execute here
  // ST_CLEAR | zero-filling bank[bank_sel], one word per cycle

  localparam int DW = LANES * BITSIZE;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DW-1:0] mem [2][DEPTH];

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              swap_pend;
  logic              swap_req_q;
  logic              swap_rise;
  logic              swap_go;
  logic              clearing;
  logic              rd_acc;
  logic              wr_acc;
  logic              rd_oor;
  logic              wr_oor;
  logic [MW-1:0]     rd_a;
  logic [MW-1:0]     wr_a;
  logic [MW-1:0]     clr_a;

  assign clearing  = (state == ST_CLEAR);
  assign clr_busy  = clearing;
  assign swap_rise = swap_req & ~swap_req_q;
  assign swap_go   = ~clearing & (swap_pend | swap_rise);

  assign rd_oor = {1'b0, rd_index} >= DEPTH_X;
  assign wr_oor = {1'b0, wr_index} >= DEPTH_X;
  assign rd_acc = en & rd;
  assign wr_acc = en & wr & ~clearing;

  // Only the low bits address the array; out-of-range indices are gated off.
  assign rd_a  = rd_index[MW-1:0];
  assign wr_a  = wr_index[MW-1:0];
  assign clr_a = clr_cnt[MW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      swap_pend  <= 1'b0;
      swap_req_q <= 1'b0;
      bank_sel   <= 1'b0;
      swap_ack   <= 1'b0;
      data_out   <= '0;
      rd_valid   <= 1'b0;
      idx_err    <= 1'b0;
    end else begin
      swap_req_q <= swap_req;
      swap_ack   <= swap_go;
      // Requests arriving mid-clear are parked until the FSM is back in IDLE.
      swap_pend  <= clearing & (swap_pend | swap_rise);
      rd_valid   <= rd_acc;
      idx_err    <= (rd_acc & rd_oor) | (wr_acc & wr_oor);
      if (rd_acc) begin
        data_out <= rd_oor ? '0 : mem[~bank_sel][rd_a];
      end
      if (swap_go) begin
        bank_sel <= ~bank_sel;
      end
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST_IDX) begin
            state <= ST_IDLE;
          end
          clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[bank_sel][clr_a] <= '0;
    end else if (wr_acc && !wr_oor) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_mask[l]) begin
          mem[bank_sel][wr_a][l*BITSIZE +: BITSIZE] <= data_in[l*BITSIZE +: BITSIZE];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bneck_pingpong.sv
// Scoreboard bench for mem_bneck_pingpong: a two-bank array model predicts read
// data, bank selection, swap/clear/index-error behaviour.
module tb_mem_bneck_pingpong;

  localparam int LANES   = 16;
  localparam int BITSIZE = 16;
  localparam int DEPTH   = 16;
  localparam int AW      = 5;
  localparam int DW      = LANES * BITSIZE;

  logic              clk;
  logic              rst;
  logic              en;
  logic              wr;
  logic [AW-1:0]     wr_index;
  logic [LANES-1:0]  wr_mask;
  logic [DW-1:0]     data_in;
  logic              rd;
  logic [AW-1:0]     rd_index;
  logic [DW-1:0]     data_out;
  logic              rd_valid;
  logic              swap_req;
  logic              swap_ack;
  logic              bank_sel;
  logic              clr_start;
  logic              clr_busy;
  logic              idx_err;

  mem_bneck_pingpong #(
    .LANES(LANES), .BITSIZE(BITSIZE), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_index(wr_index),
    .wr_mask(wr_mask), .data_in(data_in), .rd(rd), .rd_index(rd_index),
    .data_out(data_out), .rd_valid(rd_valid), .swap_req(swap_req),
    .swap_ack(swap_ack), .bank_sel(bank_sel), .clr_start(clr_start),
    .clr_busy(clr_busy), .idx_err(idx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // reference model
  logic [DW-1:0] mbank [2][DEPTH];
  logic          wsel;
  logic          pend;
  logic          prev_swap;
  int            busy_left;
  logic [DW-1:0] rq [$];
  logic [DW-1:0] last_exp;

  localparam logic [LANES-1:0] ALL = '1;
  localparam logic [DW-1:0]    ONES = '1;
  localparam logic [DW-1:0]    ZERO = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    wsel      = 1'b0;
    pend      = 1'b0;
    prev_swap = 1'b0;
    busy_left = 0;
    rq.delete();
  endtask

  // One clock of stimulus; model applies the edge's effects in order: write, swap, clear.
  task automatic step(input int i_en, input int i_wr, input int i_widx,
                      input logic [LANES-1:0] i_mask, input logic [DW-1:0] i_din,
                      input int i_rd, input int i_ridx, input int i_swp, input int i_clr);
    logic rd_acc, rd_oor, wr_acc, wr_oor, clearing, rise, do_swap;
    en        = (i_en != 0);
    wr        = (i_wr != 0);
    wr_index  = AW'(i_widx);
    wr_mask   = i_mask;
    data_in   = i_din;
    rd        = (i_rd != 0);
    rd_index  = AW'(i_ridx);
    swap_req  = (i_swp != 0);
    clr_start = (i_clr != 0);
    clearing  = (busy_left > 0);
    rd_acc    = en && rd;
    rd_oor    = (i_ridx >= DEPTH);
    wr_acc    = en && wr && !clearing;
    wr_oor    = (i_widx >= DEPTH);
    if (rd_acc) begin
      if (rd_oor) rq.push_back(ZERO);
      else        rq.push_back(mbank[!wsel][i_ridx]);
    end
    rise      = swap_req && !prev_swap;
    prev_swap = swap_req;
    @(posedge clk);
    #1;
    if (wr_acc && !wr_oor) begin
      for (int l = 0; l < LANES; l++)
        if (i_mask[l]) mbank[wsel][i_widx][l*BITSIZE +: BITSIZE] = i_din[l*BITSIZE +: BITSIZE];
    end
    do_swap = 1'b0;
    if (clearing) begin
      pend = pend || rise;
      busy_left--;
    end else begin
      if (pend || rise) begin
        wsel    = !wsel;
        pend    = 1'b0;
        do_swap = 1'b1;
      end
      if (clr_start) begin
        busy_left = DEPTH;
        for (int w = 0; w < DEPTH; w++) mbank[wsel][w] = ZERO;
      end
    end
    chk1("bank_sel", bank_sel, wsel);
    chk1("swap_ack", swap_ack, do_swap);
    chk1("clr_busy", clr_busy, busy_left > 0);
    chk1("idx_err", idx_err, (rd_acc && rd_oor) || (wr_acc && wr_oor));
    chk1("rd_valid", rd_valid, rd_acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, ALL, ZERO, 0, 0, 0, 0);
  endtask

  task automatic wr_word(input int idx, input logic [LANES-1:0] m, input logic [DW-1:0] d);
    step(1, 1, idx, m, d, 0, 0, 0, 0);
  endtask

  task automatic rd_word(input int idx);
    step(1, 0, 0, ALL, ZERO, 1, idx, 0, 0);
  endtask

  task automatic do_swap_req();
    step(0, 0, 0, ALL, ZERO, 0, 0, 1, 0);
    step(0, 0, 0, ALL, ZERO, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int w = 0; w < DEPTH; w++) rd_word(w);
    idle(1);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Starts a clear and counts busy cycles; optional swap at busy cycle swp_at,
  // and a dropped write attempt at busy cycle 5.
  task automatic clear_and_wait(input int swp_at, input int start_swap);
    int cnt;
    cnt = 0;
    step(0, 0, 0, ALL, ZERO, 0, 0, start_swap, 1);
    while (clr_busy && cnt < 100) begin
      step(1, (cnt == 5) ? 1 : 0, 2, ALL, ONES, 0, 0, (cnt == swp_at) ? 1 : 0, 0);
      cnt++;
    end
    chki("clr_len", cnt, DEPTH);
  endtask

  task automatic init_banks();
    clear_and_wait(-1, 0);
    do_swap_req();
    clear_and_wait(-1, 0);
    do_swap_req();
  endtask

  // Monitor: pop a predicted read on every rd_valid; otherwise data_out must hold.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      last_exp = ZERO;
    end else if (rd_valid) begin
      if (rq.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got rd_valid=1 with data %h, required no read pending", data_out);
      end else begin
        e = rq.pop_front();
        chkw("rd_data", data_out, e);
        last_exp = e;
      end
    end else begin
      chkw("rd_hold", data_out, last_exp);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] pat;
    logic          sw;
    last_exp  = ZERO;
    rst       = 1'b1;
    en        = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    wr_index  = '0;
    rd_index  = '0;
    wr_mask   = '0;
    data_in   = '0;
    swap_req  = 1'b0;
    clr_start = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    chk1("rst_bank_sel", bank_sel, 1'b0);
    chkw("rst_data_out", data_out, ZERO);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_swap_ack", swap_ack, 1'b0);
    chk1("rst_clr_busy", clr_busy, 1'b0);
    chk1("rst_idx_err", idx_err, 1'b0);
    #20 rst = 1'b1;

    init_banks();

    // ping-pong
    for (int l = 0; l < LANES; l++) pat[l*BITSIZE +: BITSIZE] = BITSIZE'(l + 1);
    wr_word(5, ALL, pat);
    do_swap_req();
    chk1("pp_bank_sel", bank_sel, 1'b1);
    rd_word(5);
    chkw("pp_data", data_out, pat);
    idle(1);

    // write mask
    wr_word(7, ALL, ONES);
    wr_word(7, 16'h00FF, ZERO);
    do_swap_req();
    rd_word(7);
    chkw("mask_data", data_out, {{(DW/2){1'b1}}, {(DW/2){1'b0}}});
    idle(1);

    // out of range
    rd_word(DEPTH);
    chkw("oor_rd_data", data_out, ZERO);
    wr_word(31, ALL, ONES);
    idle(1);
    step(1, 1, 31, ALL, ONES, 1, 20, 0, 0);
    idle(1);
    do_swap_req();
    read_all();

    // clear with a filled bank and a dropped write
    for (int w = 0; w < DEPTH; w++) wr_word(w, ALL, rand_word());
    clear_and_wait(-1, 0);
    do_swap_req();
    read_all();

    // swap during clear, then same-edge swap + clear
    for (int w = 0; w < DEPTH; w++) wr_word(w, ALL, rand_word());
    clear_and_wait(3, 0);
    idle(2);
    read_all();
    clear_and_wait(-1, 1);
    do_swap_req();
    read_all();

    // async reset mid-clear and mid-read
    step(0, 0, 0, ALL, ZERO, 0, 0, 0, 1);
    idle(3);
    step(0, 0, 0, ALL, ZERO, 0, 0, 1, 0);
    rd_word(3);
    #2 rst = 1'b0;
    #1;
    chk1("arst_bank_sel", bank_sel, 1'b0);
    chkw("arst_data_out", data_out, ZERO);
    chk1("arst_rd_valid", rd_valid, 1'b0);
    chk1("arst_swap_ack", swap_ack, 1'b0);
    chk1("arst_clr_busy", clr_busy, 1'b0);
    chk1("arst_idx_err", idx_err, 1'b0);
    model_reset();
    #3 rst = 1'b1;
    idle(4);
    init_banks();

    // randomized traffic
    sw = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) sw = !sw;
      step(($urandom_range(0, 9) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 31 : int'($urandom_range(0, 19)),
           LANES'($urandom),
           rand_word(),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 19)),
           sw ? 1 : 0,
           ($urandom_range(0, 39) == 0) ? 1 : 0);
    end
    idle(DEPTH + 4);
    chki("rq_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
